// File: rtl/ahb_apb_bridge_gen2.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge_gen2
//   AHB-slave to APB-master bridge. One APB transfer per accepted AHB
//   NONSEQ/SEQ beat. Addresses outside the APB window, or with a slave
//   index >= NSLV, get a two-cycle AHB ERROR with no APB activity.
//   An APB slave that never raises Pready is abandoned after TIMEOUT
//   ACCESS cycles and the master gets an ERROR.
//
// Ports
//   Hclk, Hreset       : clock, synchronous active-high reset
//   Hwrite, Hreadyin,
//   Htrans, Haddr,
//   Hwdata             : AHB request side
//   Hrdata, Hreadyout,
//   Hresp              : AHB response side (all registered)
//   Prdata, Pready,
//   Pslverr            : APB completer response
//   Pselx, Penable,
//   Pwrite, Paddr,
//   Pwdata             : APB requester outputs (all registered)
// ---------------------------------------------------------------------------
module ahb_apb_bridge_gen2 #(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter int                NSLV    = 3,
    parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
    parameter int                SEL_LSB = 26,
    parameter int                TIMEOUT = 16
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    output logic [DATA_W-1:0] Hrdata,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready,
    input  logic              Pslverr,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata
);

    localparam int SW     = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int HI_LSB = SEL_LSB + SW;
    localparam int CW     = $clog2(TIMEOUT + 1);

    localparam logic [SW:0]   NSLV_C  = (SW+1)'(NSLV);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_ERR1   = 3'd4;
    localparam logic [2:0] S_ERR2   = 3'd5;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_haddr;
    logic              r_hwrite;
    logic [SW-1:0]     r_idx;
    logic [CW-1:0]     r_wait;

    logic [DATA_W-1:0] r_hrdata;
    logic              r_hreadyout;
    logic [1:0]        r_hresp;
    logic [NSLV-1:0]   r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;

    logic              w_valid;
    logic              w_hit;
    logic [SW-1:0]     w_idx;
    logic [NSLV-1:0]   w_onehot;

    // Only NONSEQ/SEQ (Htrans[1]) start a transfer; IDLE/BUSY fall through
    // with the OKAY/ready-high response already on the outputs.
    assign w_valid = Hreadyin & r_hreadyout & Htrans[1];
    assign w_idx   = Haddr[SEL_LSB +: SW];
    assign w_hit   = (Haddr[ADDR_W-1:HI_LSB] == BASE[ADDR_W-1:HI_LSB]) &&
                     ({1'b0, w_idx} < NSLV_C);

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NSLV; i++)
            w_onehot[i] = (r_idx == SW'(i));
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state     <= S_IDLE;
            r_haddr     <= '0;
            r_hwrite    <= 1'b0;
            r_idx       <= '0;
            r_wait      <= '0;
            r_hrdata    <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= RESP_OKAY;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_hreadyout <= 1'b0;
                        if (w_hit) begin
                            r_haddr  <= Haddr;
                            r_hwrite <= Hwrite;
                            r_idx    <= w_idx;
                            r_state  <= S_LATCH;
                        end else begin
                            r_hresp <= RESP_ERROR;
                            r_state <= S_ERR1;
                        end
                    end
                end
                // Hwdata belongs to the data phase, so it is only valid now.
                S_LATCH: begin
                    r_paddr  <= r_haddr;
                    r_pwrite <= r_hwrite;
                    if (r_hwrite)
                        r_pwdata <= Hwdata;
                    r_psel   <= w_onehot;
                    r_state  <= S_SETUP;
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (Pready) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        if (Pslverr) begin
                            r_hresp <= RESP_ERROR;
                            r_state <= S_ERR1;
                        end else begin
                            r_hreadyout <= 1'b1;
                            r_hresp     <= RESP_OKAY;
                            if (!r_pwrite)
                                r_hrdata <= Prdata;
                            r_state     <= S_IDLE;
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        // This is the TIMEOUT-th ACCESS cycle with no Pready.
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_hresp   <= RESP_ERROR;
                        r_state   <= S_ERR1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                // Two-cycle AHB error: ready low then high, ERROR on both.
                S_ERR1: begin
                    r_hreadyout <= 1'b1;
                    r_state     <= S_ERR2;
                end
                S_ERR2: begin
                    r_hresp <= RESP_OKAY;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_hreadyout <= 1'b1;
                    r_hresp     <= RESP_OKAY;
                    r_psel      <= '0;
                    r_penable   <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign Hrdata    = r_hrdata;
    assign Hreadyout = r_hreadyout;
    assign Hresp     = r_hresp;
    assign Pselx     = r_psel;
    assign Penable   = r_penable;
    assign Pwrite    = r_pwrite;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;

endmodule
